// File: rtl/parking_pkg.sv
// Shared types for the parking allocator: controller states, result codes
// and the mapping from (state, result) to the three status LEDs.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CHECK = 2'd2,
        ST_SHOW  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CODE_NONE         = 3'd0,
        CODE_GRANT_CHOSEN = 3'd1,
        CODE_GRANT_ALT    = 3'd2,
        CODE_NO_SPACE     = 3'd3,
        CODE_INVALID      = 3'd4,
        CODE_EXIT_OK      = 3'd5,
        CODE_EXIT_ERR     = 3'd6
    } code_t;

    typedef struct packed {
        logic power;
        logic wrong;
        logic green;
    } leds_t;

    function automatic leds_t led_encode(state_t s, code_t c);
        leds_t l;
        l = '{power: 1'b1, wrong: 1'b0, green: 1'b0};
        case (s)
            ST_OFF:  l = '{power: 1'b0, wrong: 1'b1, green: 1'b0};
            ST_SHOW: begin
                if (c == CODE_GRANT_CHOSEN || c == CODE_GRANT_ALT || c == CODE_EXIT_OK)
                    l.green = 1'b1;
                else
                    l.wrong = 1'b1;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Free-running divider producing a one-cycle pulse every TICK_DIV clocks;
// clr restarts the count so the first pulse lands TICK_DIV cycles after release.
module tick_timer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic sec_pulse
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    assign sec_pulse = !clr && (cnt == LAST);

endmodule

// File: rtl/parking_allocator.sv
// Multi-floor parking allocator: accepts entry/exit requests, allocates or
// frees spaces, and holds each result on the display for a timed period.
module parking_allocator
    import parking_pkg::*;
#(
    parameter int NUM_FLOORS    = 4,
    parameter int CAP           = 8,
    parameter int SPECIAL_FLOOR = 0,
    parameter int TICK_DIV      = 50_000_000,
    parameter int HOLD_SEC      = 3,
    parameter int ERR_SEC       = 5,
    localparam int FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1,
    localparam int CW = $clog2(CAP + 1),
    localparam int TW = $clog2(NUM_FLOORS * CAP + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     power,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_exit,
    input  logic [FW-1:0]            req_floor,
    input  logic                     req_special,
    input  logic                     req_id_ok,
    output logic                     resp_valid,
    output logic [2:0]               resp_code,
    output logic [FW-1:0]            resp_floor,
    output logic [NUM_FLOORS*CW-1:0] free_cnt,
    output logic [TW-1:0]            total_free,
    output logic                     red_power_led,
    output logic                     red_wrong_led,
    output logic                     green_led
);

    localparam int MAX_SEC = (HOLD_SEC > ERR_SEC) ? HOLD_SEC : ERR_SEC;
    localparam int SW      = $clog2(MAX_SEC + 1);
    localparam logic [FW-1:0] SPECIAL   = FW'(SPECIAL_FLOOR);
    localparam logic [CW-1:0] FULL      = CW'(CAP);
    localparam logic [SW-1:0] HOLD_LAST = SW'(HOLD_SEC - 1);
    localparam logic [SW-1:0] ERR_LAST  = SW'(ERR_SEC - 1);

    state_t        state, state_next;
    code_t         code_q, code_next, code_d;
    leds_t         leds_q;
    logic [FW-1:0] floor_q, floor_d, resp_floor_q, alt_floor;
    logic          exit_q, special_q, id_ok_q;
    logic [CW-1:0] free [NUM_FLOORS];
    logic [TW-1:0] total_q;
    logic [SW-1:0] sec_cnt;
    logic          resp_valid_q;
    logic          accept, commit, sec_pulse, hold_done;
    logic          floor_ok, chosen_has, chosen_full, special_has, alt_found;
    logic          inc_d, dec_d;

    assign req_ready = (state == ST_IDLE) && power;
    assign accept    = req_valid && req_ready;
    assign commit    = (state == ST_CHECK) && power;

    tick_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .clr       (state != ST_SHOW),
        .sec_pulse (sec_pulse)
    );

    // Seconds elapsed in SHOW; invalid results get the longer hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sec_cnt <= '0;
        else if (state != ST_SHOW)
            sec_cnt <= '0;
        else if (sec_pulse)
            sec_cnt <= sec_cnt + SW'(1);
    end

    assign hold_done = sec_pulse &&
                       (sec_cnt == ((code_q == CODE_INVALID) ? ERR_LAST : HOLD_LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exit_q    <= 1'b0;
            floor_q   <= '0;
            special_q <= 1'b0;
            id_ok_q   <= 1'b0;
        end else if (accept) begin
            exit_q    <= req_exit;
            floor_q   <= req_floor;
            special_q <= req_special;
            id_ok_q   <= req_id_ok;
        end
    end

    // Free-floor search; descending scan leaves the lowest-index candidate
    always_comb begin
        chosen_has  = 1'b0;
        chosen_full = 1'b0;
        alt_found   = 1'b0;
        alt_floor   = '0;
        floor_ok    = int'(floor_q) < NUM_FLOORS;
        special_has = free[SPECIAL_FLOOR] != '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (FW'(i) == floor_q) begin
                chosen_has  = free[i] != '0;
                chosen_full = free[i] == FULL;
            end else if (free[i] != '0) begin
                alt_found = 1'b1;
                alt_floor = FW'(i);
            end
        end
    end

    always_comb begin
        code_d  = CODE_NONE;
        floor_d = floor_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        if (!floor_ok || (!exit_q && !id_ok_q)) begin
            code_d = CODE_INVALID;
        end else if (exit_q) begin
            if (chosen_full) begin
                code_d = CODE_EXIT_ERR;
            end else begin
                code_d = CODE_EXIT_OK;
                inc_d  = 1'b1;
            end
        end else if (special_q && special_has) begin
            floor_d = SPECIAL;
            code_d  = (floor_q == SPECIAL) ? CODE_GRANT_CHOSEN : CODE_GRANT_ALT;
            dec_d   = 1'b1;
        end else if (chosen_has) begin
            code_d = CODE_GRANT_CHOSEN;
            dec_d  = 1'b1;
        end else if (alt_found) begin
            floor_d = alt_floor;
            code_d  = CODE_GRANT_ALT;
            dec_d   = 1'b1;
        end else begin
            code_d = CODE_NO_SPACE;
        end
    end

    // Counts survive power loss; only reset refills every floor
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_FLOORS; i++)
                free[i] <= FULL;
            total_q <= TW'(NUM_FLOORS * CAP);
        end else if (commit) begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (FW'(i) == floor_d) begin
                    if (inc_d)
                        free[i] <= free[i] + CW'(1);
                    else if (dec_d)
                        free[i] <= free[i] - CW'(1);
                end
            end
            if (inc_d)
                total_q <= total_q + TW'(1);
            else if (dec_d)
                total_q <= total_q - TW'(1);
        end
    end

    always_comb begin
        state_next = state;
        if (!power) begin
            state_next = ST_OFF;
        end else begin
            case (state)
                ST_OFF:   state_next = ST_IDLE;
                ST_IDLE:  if (req_valid) state_next = ST_CHECK;
                ST_CHECK: state_next = ST_SHOW;
                ST_SHOW:  if (hold_done) state_next = ST_IDLE;
                default:  state_next = ST_OFF;
            endcase
        end
    end

    always_comb begin
        code_next = code_q;
        if (state_next == ST_OFF || state_next == ST_IDLE)
            code_next = CODE_NONE;
        else if (commit)
            code_next = code_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_OFF;
            code_q       <= CODE_NONE;
            resp_floor_q <= '0;
            resp_valid_q <= 1'b0;
            leds_q       <= '{power: 1'b0, wrong: 1'b1, green: 1'b0};
        end else begin
            state        <= state_next;
            code_q       <= code_next;
            resp_valid_q <= commit;
            leds_q       <= led_encode(state_next, code_next);
            if (commit)
                resp_floor_q <= floor_d;
        end
    end

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_pack
        assign free_cnt[g*CW +: CW] = free[g];
    end

    assign total_free    = total_q;
    assign resp_valid    = resp_valid_q;
    assign resp_code     = code_q;
    assign resp_floor    = resp_floor_q;
    assign red_power_led = leds_q.power;
    assign red_wrong_led = leds_q.wrong;
    assign green_led     = leds_q.green;

endmodule

// File: tb/tb_parking_allocator.sv
// Bench for parking_allocator: directed scenarios followed by random requests,
// each checked against a rule-level model of floor occupancy.
module tb_parking_allocator;

    localparam int NF   = 3;
    localparam int CAP  = 2;
    localparam int TD   = 4;
    localparam int HOLD = 3;
    localparam int ERR  = 5;

    logic       clk = 1'b0;
    logic       reset, power, req_valid, req_exit, req_special, req_id_ok;
    logic [1:0] req_floor;
    logic       req_ready, resp_valid;
    logic [2:0] resp_code;
    logic [1:0] resp_floor;
    logic [5:0] free_cnt;
    logic [2:0] total_free;
    logic       red_power_led, red_wrong_led, green_led;

    int n_checks = 0;
    int n_fail   = 0;
    int free_m [NF];

    parking_allocator #(
        .NUM_FLOORS    (NF),
        .CAP           (CAP),
        .SPECIAL_FLOOR (0),
        .TICK_DIV      (TD),
        .HOLD_SEC      (HOLD),
        .ERR_SEC       (ERR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .power         (power),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_exit      (req_exit),
        .req_floor     (req_floor),
        .req_special   (req_special),
        .req_id_ok     (req_id_ok),
        .resp_valid    (resp_valid),
        .resp_code     (resp_code),
        .resp_floor    (resp_floor),
        .free_cnt      (free_cnt),
        .total_free    (total_free),
        .red_power_led (red_power_led),
        .red_wrong_led (red_wrong_led),
        .green_led     (green_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] exp_free();
        return {2'(free_m[2]), 2'(free_m[1]), 2'(free_m[0])};
    endfunction

    function automatic logic [2:0] exp_total();
        return 3'(free_m[0] + free_m[1] + free_m[2]);
    endfunction

    function automatic logic [2:0] leds();
        return {red_power_led, red_wrong_led, green_led};
    endfunction

    // Result rules applied to the occupancy model; updates counts on a grant/exit
    task automatic model_decide(input logic ex, input logic [1:0] fl, input logic sp,
                                input logic ok, output logic [2:0] ec, output logic [1:0] ef);
        int f;
        f  = int'(fl);
        ef = fl;
        ec = 3'd3;
        if (f >= NF || (!ex && !ok)) begin
            ec = 3'd4;
        end else if (ex) begin
            if (free_m[f] == CAP) ec = 3'd6;
            else begin ec = 3'd5; free_m[f] += 1; end
        end else if (sp && free_m[0] > 0) begin
            ec = (f == 0) ? 3'd1 : 3'd2;
            ef = 2'd0;
            free_m[0] -= 1;
        end else if (free_m[f] > 0) begin
            ec = 3'd1;
            free_m[f] -= 1;
        end else begin
            for (int k = 0; k < NF; k++) begin
                if (ec == 3'd3 && k != f && free_m[k] > 0) begin
                    ec = 3'd2;
                    ef = 2'(k);
                    free_m[k] -= 1;
                end
            end
        end
    endtask

    task automatic transact(input logic ex, input logic [1:0] fl, input logic sp,
                            input logic ok, input int drop_at);
        int waited;
        int show_len;
        logic [2:0] ec;
        logic [1:0] ef;
        logic good;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", req_ready, 1);
        model_decide(ex, fl, sp, ok, ec, ef);
        req_valid = 1'b1; req_exit = ex; req_floor = fl; req_special = sp; req_id_ok = ok;
        @(negedge clk);
        req_valid = 1'b0;
        check("check_ready", req_ready, 0);
        check("check_valid", resp_valid, 0);
        @(negedge clk);
        good = (ec == 3'd1 || ec == 3'd2 || ec == 3'd5);
        check("resp_valid", resp_valid, 1);
        check("resp_code", resp_code, ec);
        check("resp_floor", resp_floor, ef);
        check("free_cnt", free_cnt, exp_free());
        check("total_free", total_free, exp_total());
        check("show_leds", leds(), good ? 3'b101 : 3'b110);
        if (drop_at >= 0) begin
            repeat (drop_at) @(negedge clk);
            power = 1'b0;
            @(negedge clk);
            check("off_ready", req_ready, 0);
            check("off_code", resp_code, 0);
            check("off_leds", leds(), 3'b010);
            check("off_free", free_cnt, exp_free());
            power = 1'b1;
            @(negedge clk);
            check("repower_ready", req_ready, 1);
            return;
        end
        show_len = 1;
        @(negedge clk);
        check("pulse_once", resp_valid, 0);
        while (req_ready !== 1'b1 && show_len < 40) begin
            show_len++;
            @(negedge clk);
        end
        check("show_len", show_len, ((ec == 3'd4) ? ERR : HOLD) * TD);
        check("idle_code", resp_code, 0);
        check("idle_leds", leds(), 3'b100);
    endtask

    initial begin
        reset = 1'b1; power = 1'b0; req_valid = 1'b0; req_exit = 1'b0;
        req_floor = '0; req_special = 1'b0; req_id_ok = 1'b0;
        for (int k = 0; k < NF; k++) free_m[k] = CAP;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_code", resp_code, 0);
        check("rst_floor", resp_floor, 0);
        check("rst_free", free_cnt, 6'b10_10_10);
        check("rst_total", total_free, 6);
        check("rst_leds", leds(), 3'b010);
        reset = 1'b0;
        @(negedge clk);
        check("off_no_power", req_ready, 0);
        power = 1'b1;
        @(negedge clk);
        check("idle_ready", req_ready, 1);
        check("idle_leds0", leds(), 3'b100);

        // Fill floor 1, then an entry there spills to floor 0
        transact(0, 2'd1, 0, 1, -1);
        transact(0, 2'd1, 0, 1, -1);
        transact(0, 2'd1, 0, 1, -1);
        // Free floor 1 back up; special IDs go to floor 0 first
        transact(1, 2'd1, 0, 1, -1);
        transact(1, 2'd1, 0, 1, -1);
        transact(0, 2'd1, 1, 1, -1);
        transact(0, 2'd1, 1, 1, -1);
        // Fill everything, then a normal entry finds no space
        transact(0, 2'd1, 0, 1, -1);
        transact(0, 2'd2, 0, 1, -1);
        transact(0, 2'd2, 0, 1, -1);
        transact(0, 2'd0, 0, 1, -1);
        // Exit errors and invalid requests
        transact(1, 2'd0, 0, 1, -1);
        transact(1, 2'd0, 0, 1, -1);
        transact(1, 2'd0, 0, 1, -1);
        transact(0, 2'd2, 0, 0, -1);
        transact(0, 2'd3, 0, 1, -1);
        transact(1, 2'd3, 0, 1, -1);
        // Power loss partway through the hold
        transact(0, 2'd2, 0, 1, 3);
        transact(1, 2'd1, 0, 1, 5);

        // Asynchronous reset while the request is in CHECK
        while (req_ready !== 1'b1) @(negedge clk);
        req_valid = 1'b1; req_exit = 1'b0; req_floor = 2'd2; req_special = 1'b0; req_id_ok = 1'b1;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("arst_ready", req_ready, 0);
        check("arst_valid", resp_valid, 0);
        check("arst_code", resp_code, 0);
        check("arst_floor", resp_floor, 0);
        check("arst_free", free_cnt, 6'b10_10_10);
        check("arst_total", total_free, 6);
        check("arst_leds", leds(), 3'b010);
        for (int k = 0; k < NF; k++) free_m[k] = CAP;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("arst_idle", req_ready, 1);

        for (int n = 0; n < 40; n++) begin
            transact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
